// File: rtl/vga_pixel_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_stage_pkg
// Description : Shared definitions for the VGA pixel stage. Holds the default
//               800x600 timing constants, the vertical FSM state encoding and
//               the 4-bit colour levels.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pixel_stage_pkg;

    // Default timing constants (800x600 class mode)
    localparam int C_H_VISIBLE = 800;
    localparam int C_V_VISIBLE = 600;
    localparam int C_V_FRONT   = 37;
    localparam int C_V_SYNC    = 6;
    localparam int C_V_BACK    = 23;
    localparam int C_BAR_W     = 100;

    // Vertical FSM states
    typedef enum logic [1:0] {
        VS_VIS   = 2'd0,
        VS_FRONT = 2'd1,
        VS_SYNC  = 2'd2,
        VS_BACK  = 2'd3
    } vstate_e;

    // Plain-vector copies of the state encoding for legacy state registers
    localparam logic [1:0] C_ST_V_VIS   = VS_VIS;
    localparam logic [1:0] C_ST_V_FRONT = VS_FRONT;
    localparam logic [1:0] C_ST_V_SYNC  = VS_SYNC;
    localparam logic [1:0] C_ST_V_BACK  = VS_BACK;

    // Colour channel levels
    localparam logic [3:0] C_COLOR_ON  = 4'hF;
    localparam logic [3:0] C_COLOR_OFF = 4'h0;

endpackage
`default_nettype wire

// File: rtl/vga_pixel_stage_line_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_counter
// Description : Vertical timing: line counter advanced by newline pulses,
//               vertical FSM (visible / front porch / sync / back porch),
//               vsync level and a one-cycle wrap flag that is high in the
//               first cycle the counter reads 0 after a wrap.
// Ports       : ck         - pixel clock
//               reset      - synchronous, active-low reset
//               newline    - advance the counter by one line per high cycle
//               line_count - current line number
//               state      - current vertical state
//               vsync      - 0 during sync lines, 1 otherwise
//               wrap       - one-cycle flag after wrapping to line 0
// Revision    : 1.0 - initial release
// ============================================================================
module vga_line_counter
    import vga_pixel_stage_pkg::*;
#(
    parameter int V_VISIBLE = C_V_VISIBLE,
    parameter int V_FRONT   = C_V_FRONT,
    parameter int V_SYNC    = C_V_SYNC,
    parameter int V_BACK    = C_V_BACK
) (
    input  logic        ck,
    input  logic        reset,
    input  logic        newline,
    output logic [11:0] line_count,
    output logic [1:0]  state,
    output logic        vsync,
    output logic        wrap
);

    // Last line number of each vertical region
    localparam logic [11:0] c_LAST_VIS   = 12'(V_VISIBLE - 1);
    localparam logic [11:0] c_LAST_FRONT = 12'(V_VISIBLE + V_FRONT - 1);
    localparam logic [11:0] c_LAST_SYNC  = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [11:0] c_LAST_LINE  = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [11:0] r_line;
    logic [1:0]  r_state;
    logic        r_wrap;
    logic        w_last;

    assign w_last = (r_line == c_LAST_LINE);

    always_ff @(posedge ck) begin
        if (!reset) begin
            r_line  <= 12'd0;
            r_state <= C_ST_V_VIS;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= newline && w_last;
            if (newline) begin
                r_line <= w_last ? 12'd0 : r_line + 12'd1;
                // State changes on the same edge the counter leaves the
                // last line of a region, so state and counter never disagree.
                case (r_state)
                    C_ST_V_VIS:   if (r_line == c_LAST_VIS)   r_state <= C_ST_V_FRONT;
                    C_ST_V_FRONT: if (r_line == c_LAST_FRONT) r_state <= C_ST_V_SYNC;
                    C_ST_V_SYNC:  if (r_line == c_LAST_SYNC)  r_state <= C_ST_V_BACK;
                    C_ST_V_BACK:  if (w_last)                 r_state <= C_ST_V_VIS;
                    default:                                  r_state <= C_ST_V_VIS;
                endcase
            end
        end
    end

    assign line_count = r_line;
    assign state      = r_state;
    assign vsync      = (r_state != C_ST_V_SYNC);
    assign wrap       = r_wrap;

endmodule
`default_nettype wire

// File: rtl/vga_pixel_stage.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_stage
// Description : Pixel stage of a VGA controller. Tracks vertical timing from
//               newline pulses, decodes eight vertical colour bars from the
//               horizontal position and registers colour, syncs and the
//               frame-start pulse through a two-stage pipeline so that all
//               outputs stay mutually aligned.
// Ports       : ck          - pixel clock
//               reset       - synchronous, active-low reset
//               h_position  - current pixel column
//               h_active    - horizontal visible area
//               h_sync      - horizontal sync level (polarity preserved)
//               newline     - one-cycle pulse at end of each line
//               red/green/blue - 4-bit colour, two cycles after inputs
//               hsync_o/vsync_o - aligned sync levels
//               v_position  - current line number (not pipelined)
//               frame_start - one-cycle pulse at the first slot of line 0
// Options     : VGA_BORDER_EN - when defined, draws a white one-pixel border
//               around the visible area.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_stage
    import vga_pixel_stage_pkg::*;
#(
    parameter int H_VISIBLE = C_H_VISIBLE,
    parameter int V_VISIBLE = C_V_VISIBLE,
    parameter int V_FRONT   = C_V_FRONT,
    parameter int V_SYNC    = C_V_SYNC,
    parameter int V_BACK    = C_V_BACK,
    parameter int BAR_W     = C_BAR_W
) (
    input  logic        ck,
    input  logic        reset,
    input  logic [11:0] h_position,
    input  logic        h_active,
    input  logic        h_sync,
    input  logic        newline,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [11:0] v_position,
    output logic        frame_start
);

    logic [1:0] w_state;
    logic       w_vsync;
    logic       w_wrap;
    logic       w_pix_active;
    logic [2:0] w_bar_idx;

    vga_line_counter #(
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_line_counter (
        .ck         (ck),
        .reset      (reset),
        .newline    (newline),
        .line_count (v_position),
        .state      (w_state),
        .vsync      (w_vsync),
        .wrap       (w_wrap)
    );

    assign w_pix_active = h_active && (w_state == C_ST_V_VIS);

    // Bar index = h_position / BAR_W clamped to 7, built as a threshold
    // chain. Thresholds at or beyond the visible width can never be hit by
    // an active pixel, so they are left out.
    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ((k * BAR_W < H_VISIBLE) && (h_position >= 12'(k * BAR_W))) begin
                w_bar_idx = 3'(k);
            end
        end
    end

`ifdef VGA_BORDER_EN
    logic w_border;
    logic r_s1_border;

    assign w_border = (h_position == 12'd0)
                   || (h_position == 12'(H_VISIBLE - 1))
                   || (v_position == 12'd0)
                   || (v_position == 12'(V_VISIBLE - 1));

    always_ff @(posedge ck) begin
        if (!reset) begin
            r_s1_border <= 1'b0;
        end else begin
            r_s1_border <= w_border;
        end
    end
`endif

    // Stage 1: decoded pixel attributes and sync/frame flags
    logic       r_s1_active;
    logic [2:0] r_s1_idx;
    logic       r_s1_hsync;
    logic       r_s1_vsync;
    logic       r_s1_frame;

    always_ff @(posedge ck) begin
        if (!reset) begin
            r_s1_active <= 1'b0;
            r_s1_idx    <= 3'd0;
            r_s1_hsync  <= 1'b1;
            r_s1_vsync  <= 1'b1;
            r_s1_frame  <= 1'b0;
        end else begin
            r_s1_active <= w_pix_active;
            r_s1_idx    <= w_bar_idx;
            r_s1_hsync  <= h_sync;
            r_s1_vsync  <= w_vsync;
            r_s1_frame  <= w_wrap;
        end
    end

    // Colour from stage-1 attributes; blank outside the active area
    logic [3:0] w_red;
    logic [3:0] w_green;
    logic [3:0] w_blue;

    always_comb begin
        w_red   = C_COLOR_OFF;
        w_green = C_COLOR_OFF;
        w_blue  = C_COLOR_OFF;
        if (r_s1_active) begin
            w_red   = r_s1_idx[2] ? C_COLOR_ON : C_COLOR_OFF;
            w_green = r_s1_idx[1] ? C_COLOR_ON : C_COLOR_OFF;
            w_blue  = r_s1_idx[0] ? C_COLOR_ON : C_COLOR_OFF;
`ifdef VGA_BORDER_EN
            if (r_s1_border) begin
                w_red   = C_COLOR_ON;
                w_green = C_COLOR_ON;
                w_blue  = C_COLOR_ON;
            end
`endif
        end
    end

    // Stage 2: output registers
    logic [3:0] r_red;
    logic [3:0] r_green;
    logic [3:0] r_blue;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame;

    always_ff @(posedge ck) begin
        if (!reset) begin
            r_red   <= C_COLOR_OFF;
            r_green <= C_COLOR_OFF;
            r_blue  <= C_COLOR_OFF;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
            r_hsync <= r_s1_hsync;
            r_vsync <= r_s1_vsync;
            r_frame <= r_s1_frame;
        end
    end

    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign hsync_o     = r_hsync;
    assign vsync_o     = r_vsync;
    assign frame_start = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pixel_stage
// Description : Self-checking bench for vga_pixel_stage with default timing:
//               reset state, a table of bar-colour vectors, a full frame of
//               newline pulses (vsync window, wrap, frame_start alignment),
//               the front-porch blanking, optional border and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_stage;

    localparam int c_LAST_LINE  = 665;
    localparam int c_SYNC_FIRST = 637;
    localparam int c_SYNC_LAST  = 642;

    logic        ck;
    logic        reset;
    logic [11:0] h_position;
    logic        h_active;
    logic        h_sync;
    logic        newline;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync_o;
    logic        vsync_o;
    logic [11:0] v_position;
    logic        frame_start;

    vga_pixel_stage u_dut (
        .ck          (ck),
        .reset       (reset),
        .h_position  (h_position),
        .h_active    (h_active),
        .h_sync      (h_sync),
        .newline     (newline),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .v_position  (v_position),
        .frame_start (frame_start)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int checks = 0;
    int passed = 0;
    int exp_line = 0;

    typedef struct {
        logic [11:0] h;
        logic        act;
        logic        hs;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (line %0d)", name, act, exp, exp_line);
    endtask

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    // Apply one pixel for two cycles and compare the pipelined colour/hsync
    task automatic pix(input string name, input logic [11:0] h, input logic act,
                       input logic hs, input logic [11:0] exp_rgb);
        h_position = h;
        h_active   = act;
        h_sync     = hs;
        tick;
        tick;
        check(name, {red, green, blue, hsync_o}, {exp_rgb, hs});
        h_active = 1'b0;
        h_sync   = 1'b1;
    endtask

    // One newline pulse; h_sync is dropped for exactly the first cycle of the
    // new line so the frame_start pulse can be checked against it.
    task automatic pulse_line;
        logic fs_exp;
        fs_exp   = (exp_line == c_LAST_LINE);
        exp_line = fs_exp ? 0 : exp_line + 1;
        newline = 1'b1;
        tick;
        newline = 1'b0;
        h_sync  = 1'b0;
        tick;
        h_sync  = 1'b1;
        tick;
        check("v_position", v_position, exp_line);
        check("vsync_o", vsync_o, !(exp_line >= c_SYNC_FIRST && exp_line <= c_SYNC_LAST));
        check("frame_start", frame_start, fs_exp);
        check("hsync_o marker", hsync_o, 1'b0);
        tick;
        check("frame_start width", frame_start, 1'b0);
        check("hsync_o after marker", hsync_o, 1'b1);
    endtask

    initial begin
        logic [11:0] e;

        vecs[0]  = '{12'd250,  1'b1, 1'b1, 12'h0F0};
        vecs[1]  = '{12'd0,    1'b1, 1'b0, 12'h000};
        vecs[2]  = '{12'd99,   1'b1, 1'b1, 12'h000};
        vecs[3]  = '{12'd100,  1'b1, 1'b0, 12'h00F};
        vecs[4]  = '{12'd199,  1'b1, 1'b1, 12'h00F};
        vecs[5]  = '{12'd350,  1'b1, 1'b1, 12'h0FF};
        vecs[6]  = '{12'd400,  1'b1, 1'b0, 12'hF00};
        vecs[7]  = '{12'd555,  1'b1, 1'b1, 12'hF0F};
        vecs[8]  = '{12'd699,  1'b1, 1'b1, 12'hFF0};
        vecs[9]  = '{12'd700,  1'b1, 1'b0, 12'hFFF};
        vecs[10] = '{12'd799,  1'b1, 1'b1, 12'hFFF};
        vecs[11] = '{12'd2000, 1'b1, 1'b1, 12'hFFF};
        vecs[12] = '{12'd250,  1'b0, 1'b1, 12'h000};
        vecs[13] = '{12'd700,  1'b0, 1'b0, 12'h000};

        // Reset with busy inputs: outputs must still come out idle
        reset      = 1'b0;
        h_position = 12'd250;
        h_active   = 1'b1;
        h_sync     = 1'b0;
        newline    = 1'b1;
        repeat (3) tick;
        check("reset rgb", {red, green, blue}, 12'h000);
        check("reset hsync_o", hsync_o, 1'b1);
        check("reset vsync_o", vsync_o, 1'b1);
        check("reset v_position", v_position, 12'd0);
        check("reset frame_start", frame_start, 1'b0);

        reset    = 1'b1;
        newline  = 1'b0;
        h_active = 1'b0;
        h_sync   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("no frame_start at reset exit", frame_start, 1'b0);
        end

        // A newline held high for 10 cycles advances 10 lines
        newline = 1'b1;
        repeat (10) tick;
        newline = 1'b0;
        exp_line = 10;
        check("held newline count", v_position, 12'd10);

        // Bar vectors on line 10
        for (int i = 0; i < 14; i++) begin
            e = vecs[i].rgb;
`ifdef VGA_BORDER_EN
            if (vecs[i].act && (vecs[i].h == 12'd0 || vecs[i].h == 12'd799)) e = 12'hFFF;
`endif
            pix($sformatf("bar vec %0d", i), vecs[i].h, vecs[i].act, vecs[i].hs, e);
        end

        // Rest of the frame, checking the last visible and first porch line
        while (exp_line != c_LAST_LINE) begin
            pulse_line;
            if (exp_line == 599) begin
`ifdef VGA_BORDER_EN
                pix("line 599 active", 12'd250, 1'b1, 1'b1, 12'hFFF);
`else
                pix("line 599 active", 12'd250, 1'b1, 1'b1, 12'h0F0);
`endif
            end
            if (exp_line == 600) pix("line 600 blank", 12'd250, 1'b1, 1'b1, 12'h000);
        end

        // Wrap: line 0, visible again on the same edge, one frame_start
        pulse_line;
`ifdef VGA_BORDER_EN
        pix("line 0 after wrap", 12'd250, 1'b1, 1'b0, 12'hFFF);
`else
        pix("line 0 after wrap", 12'd250, 1'b1, 1'b0, 12'h0F0);
`endif

`ifdef VGA_BORDER_EN
        while (exp_line != 5) pulse_line;
        pix("border h0 line5", 12'd0, 1'b1, 1'b1, 12'hFFF);
        pix("border h1 line5", 12'd1, 1'b1, 1'b1, 12'h000);
`endif

        // Mid-frame reset: counting restarts from line 0
        while (exp_line != 8) pulse_line;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        exp_line = 0;
        check("mid-frame reset v_position", v_position, 12'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("no frame_start after mid reset", frame_start, 1'b0);
        end
        pulse_line;
        check("line after mid reset", v_position, 12'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pixel_stage.md
VGA_PIXEL_STAGE -- requirements
Module: vga_pixel_stage

Interface
REQ-001 Parameter: H_VISIBLE, default 800, visible pixels per line.
REQ-002 Parameter: V_VISIBLE, default 600, visible lines per frame.
REQ-003 Parameter: V_FRONT, default 37, vertical front-porch lines.
REQ-004 Parameter: V_SYNC, default 6, vertical sync lines.
REQ-005 Parameter: V_BACK, default 23, vertical back-porch lines.
REQ-006 Parameter: BAR_W, default 100, colour-bar width in pixels.
REQ-007 Port: ck  input  1  pixel clock; all logic on its rising edge.
REQ-008 Port: reset  input  1  reset, synchronous, active-low.
REQ-009 Port: h_position  input  12  current pixel column from the horizontal timing stage.
REQ-010 Port: h_active  input  1  high while the pixel is in the horizontal visible area.
REQ-011 Port: h_sync  input  1  horizontal sync level from the timing stage, passed through unchanged in polarity.
REQ-012 Port: newline  input  1  one-cycle pulse at end of each line.
REQ-013 Port: red, green, blue  output  4 each  pixel colour.
REQ-014 Port: hsync_o, vsync_o  output  1 each  aligned sync levels to the connector.
REQ-015 Port: v_position  output  12  current line number, unaligned (counter value).
REQ-016 Port: frame_start  output  1  one-cycle pulse aligned with the first pixel slot of line 0.

Function
REQ-017 Vertical FSM states: V_VIS, V_FRONT, V_SYNC, V_BACK; the line counter advances only on cycles where newline=1.
REQ-018 Transitions: V_VIS -> V_FRONT after V_VISIBLE lines, V_FRONT -> V_SYNC after V_FRONT lines, V_SYNC -> V_BACK after V_SYNC lines, V_BACK -> V_VIS after V_BACK lines; the line counter wraps from V_VISIBLE+V_FRONT+V_SYNC+V_BACK-1 (665 by default) to 0.
REQ-019 v_position equals the line counter; it is 0 immediately after reset and after each wrap.
REQ-020 vsync level is 0 in V_SYNC and 1 in every other state.
REQ-021 Pixel active = h_active AND (state == V_VIS).
REQ-022 Bar index = h_position / BAR_W, clamped to 7, computed as a comparison chain with no divider; red = {4{idx[2]}}, green = {4{idx[1]}}, blue = {4{idx[0]}}.
REQ-023 RGB is 0 whenever pixel active is 0.
REQ-024 Latency: two ck cycles from inputs to RGB; hsync_o, vsync_o and frame_start are delayed through the same two stages so that all outputs stay mutually aligned.
REQ-025 frame_start is asserted for exactly one cycle, two cycles after the first cycle in which the line counter equals 0 following a wrap; no pulse is generated at reset exit.
REQ-026 If newline=1 coincides with the last line of V_BACK, the counter wraps and the state enters V_VIS in the same edge.
REQ-027 A newline pulse held for k cycles advances the line counter k times, with no de-glitching.

Reset
REQ-028 While reset=0 at a ck edge: line counter=0, state=V_VIS, both pipeline stages cleared, RGB=0, hsync_o=1, vsync_o=1, frame_start=0.
REQ-029 Reset applied mid-frame aborts the frame; counting restarts at line 0 on the next newline after release.

Configuration
REQ-030 Macro VGA_BORDER_EN: when defined, an active pixel with h_position 0 or H_VISIBLE-1, or on line 0 or V_VISIBLE-1, outputs RGB = 4'hF,4'hF,4'hF, overriding the bars with no change in latency.
REQ-031 When VGA_BORDER_EN is undefined, colour bars only are output and no border logic is present.

Structure
REQ-032 A shared package holds the default timing constants (H/V visible, porch and sync values), the FSM state enum and the 4-bit colour constants.
REQ-033 Sub-module vga_line_counter (vertical FSM, line counter, vsync, wrap flag) is instantiated once; bar decode and the pipeline stay in the top level.

Verification
REQ-034 reset=0 for 3 cycles -> RGB=0, hsync_o=1, vsync_o=1, v_position=0, frame_start=0.
REQ-035 h_active=1, h_position=250, line 10 -> two cycles later RGB = 0/F/0 (index 2).
REQ-036 665 newline pulses after reset -> vsync_o=0 exactly during lines 637-642; v_position returns to 0 after the 666th pulse.
REQ-037 Wrap to line 0 -> single frame_start pulse two cycles later, coincident with the delayed hsync_o sample.
REQ-038 h_active=1 on line 600 (V_FRONT) -> RGB=0.
REQ-039 With VGA_BORDER_EN: h_position=0, line 5, active -> RGB=F/F/F; h_position=1 -> bar colour 0/0/0.
